// File: rtl/squeeze_serializer.sv
// Squeeze-phase output stage of the Haraka-S sponge: shifts rate blocks out
// LSB first over a valid/ready handshake and requests more blocks as needed.
module squeeze_serializer #(
  parameter int unsigned INWIDTH  = 256,
  parameter int unsigned OUTWIDTH = 1,
  parameter int unsigned LENWIDTH = 16
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic [LENWIDTH-1:0] out_len,
  input  logic [INWIDTH-1:0]  block_in,
  input  logic                block_valid,
  output logic                block_ready,
  output logic                next_block,
  output logic [OUTWIDTH-1:0] serial_out,
  output logic                serial_valid,
  input  logic                serial_ready,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BEATS = INWIDTH / OUTWIDTH;
  localparam int unsigned CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [INWIDTH-1:0]  shreg_q, shreg_d;
  logic [LENWIDTH-1:0] remaining_q, remaining_d;
  logic [CNTW-1:0]     beat_cnt_q, beat_cnt_d;
  logic                block_ready_q, block_ready_d;
  logic                next_block_q, next_block_d;
  logic                serial_valid_q, serial_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic; outputs are registered decodes of the next state.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    remaining_d  = remaining_q;
    beat_cnt_d   = beat_cnt_q;
    next_block_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (out_len != '0) begin
            remaining_d = out_len;
            state_d     = WAIT_BLK;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT_BLK: begin
        if (block_valid) begin
          shreg_d    = block_in;
          beat_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (serial_ready) begin
          shreg_d     = shreg_q >> OUTWIDTH;
          remaining_d = remaining_q - LENWIDTH'(1);
          beat_cnt_d  = beat_cnt_q + CNTW'(1);
          // The final beat wins over a block boundary: no further block is requested.
          if (remaining_q == LENWIDTH'(1)) begin
            state_d = DONE;
          end else if (beat_cnt_q == CNTW'(BEATS - 1)) begin
            next_block_d = 1'b1;
            state_d      = WAIT_BLK;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    block_ready_d  = (state_d == WAIT_BLK);
    serial_valid_d = (state_d == SHIFT);
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      remaining_q    <= '0;
      beat_cnt_q     <= '0;
      block_ready_q  <= 1'b0;
      next_block_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      remaining_q    <= remaining_d;
      beat_cnt_q     <= beat_cnt_d;
      block_ready_q  <= block_ready_d;
      next_block_q   <= next_block_d;
      serial_valid_q <= serial_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign block_ready  = block_ready_q;
  assign next_block   = next_block_q;
  assign serial_out   = shreg_q[OUTWIDTH-1:0];
  assign serial_valid = serial_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
